// File: rtl/phase_meas_pkg.sv
// Shared encodings for the phase-measurement sequencer: FSM states and
// the status codes published with each result.
package phase_meas_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD1      = 3'd1,
        RD2      = 3'd2,
        FILL     = 3'd3,
        PUSH     = 3'd4,
        WAIT_RES = 3'd5,
        DONE     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_LOWCONF = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_BADBIN  = 2'd3
    } status_t;

    // Bin 0 is DC and bins at or above NFFT/2 are mirror images.
    function automatic logic bin_ok(input logic [9:0] bin, input int nfft_half);
        return (bin != 10'd0) && (int'(bin) < nfft_half);
    endfunction

endpackage

// File: rtl/phase_meas_sequencer.sv
// One phase-difference measurement per FFT frame: fetch both channels'
// fundamental bin, push the pair to the calculator, then gate its result.
module phase_meas_sequencer
    import phase_meas_pkg::*;
#(
    parameter int RD_LAT    = 2,
    parameter int NFFT_HALF = 512,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_done,
    input  logic [9:0]         fund_bin,
    input  logic [7:0]         conf_thresh,
    output logic               mem_rd_en,
    output logic               mem_rd_ch,
    output logic [9:0]         mem_rd_addr,
    input  logic signed [15:0] mem_rd_re,
    input  logic signed [15:0] mem_rd_im,
    output logic               calc_enable,
    output logic signed [15:0] ch1_re,
    output logic signed [15:0] ch1_im,
    output logic signed [15:0] ch2_re,
    output logic signed [15:0] ch2_im,
    output logic               ch1_valid,
    output logic               ch2_valid,
    input  logic signed [15:0] calc_phase,
    input  logic               calc_valid,
    input  logic [7:0]         calc_conf,
    output logic signed [15:0] phase_out,
    output logic [1:0]         status,
    output logic               result_valid,
    output logic               busy,
    output logic [7:0]         overrun_cnt
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              state;
    status_t             status_q;
    logic [CW-1:0]       tmo_cnt;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT-1:0]   ch_pipe;

    wire rd_ret    = vld_pipe[RD_LAT-1];
    wire rd_ret_ch = ch_pipe[RD_LAT-1];

    assign status = status_q;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            status_q     <= ST_OK;
            tmo_cnt      <= '0;
            vld_pipe     <= '0;
            ch_pipe      <= '0;
            mem_rd_en    <= 1'b0;
            mem_rd_ch    <= 1'b0;
            mem_rd_addr  <= '0;
            calc_enable  <= 1'b0;
            ch1_re       <= '0;
            ch1_im       <= '0;
            ch2_re       <= '0;
            ch2_im       <= '0;
            ch1_valid    <= 1'b0;
            ch2_valid    <= 1'b0;
            phase_out    <= '0;
            result_valid <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            calc_enable  <= 1'b1;
            ch1_valid    <= 1'b0;
            ch2_valid    <= 1'b0;
            result_valid <= 1'b0;

            // Track each issued read so its data is captured RD_LAT cycles later.
            vld_pipe[0] <= mem_rd_en;
            ch_pipe[0]  <= mem_rd_ch;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                ch_pipe[i]  <= ch_pipe[i-1];
            end
            if (rd_ret) begin
                if (rd_ret_ch) begin
                    ch2_re <= mem_rd_re;
                    ch2_im <= mem_rd_im;
                end else begin
                    ch1_re <= mem_rd_re;
                    ch1_im <= mem_rd_im;
                end
            end

            if (frame_done && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (frame_done) begin
                        if (bin_ok(fund_bin, NFFT_HALF)) begin
                            state       <= RD1;
                            mem_rd_en   <= 1'b1;
                            mem_rd_ch   <= 1'b0;
                            mem_rd_addr <= fund_bin;
                        end else begin
                            state    <= DONE;
                            status_q <= ST_BADBIN;
                        end
                    end
                end
                RD1: begin
                    state     <= RD2;
                    mem_rd_ch <= 1'b1;
                end
                RD2: begin
                    state     <= FILL;
                    mem_rd_en <= 1'b0;
                end
                FILL: begin
                    // ch2 is always the later return, so its arrival completes the pair.
                    if (rd_ret && rd_ret_ch) begin
                        state     <= PUSH;
                        ch1_valid <= 1'b1;
                        ch2_valid <= 1'b1;
                    end
                end
                PUSH: begin
                    state   <= WAIT_RES;
                    tmo_cnt <= '0;
                end
                WAIT_RES: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (calc_valid) begin
                        state <= DONE;
                        if (calc_conf >= conf_thresh) begin
                            status_q  <= ST_OK;
                            phase_out <= calc_phase;
                        end else begin
                            status_q <= ST_LOWCONF;
                        end
                    end else if (tmo_cnt == CW'(TIMEOUT - 2)) begin
                        state    <= DONE;
                        status_q <= ST_TIMEOUT;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    result_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
